load_store_unit: RTL and testbench

//  Parametrised load/store unit between the multicycle core's control FSM (MEMADR/MEMREAD/MEMWRITE)
//  and a variable-latency data memory. Accepts one byte/half/word(/double) access at a time.

---
 rtl/pkg_lsu.sv | 55 +++++
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_lsu.sv
// Shared types and request-decode helpers for the load/store unit.
// Covers funct3 legality and natural-alignment checks.
package pkg_lsu;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR
  } state_t;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_D  = 3'b011,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101,
    LSU_WU = 3'b110
  } funct3_t;

  function automatic logic width_legal(
    input logic       we,
    input logic [2:0] f3,
    input logic       is64
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      LSU_B, LSU_H, LSU_W: ok = 1'b1;
      LSU_BU, LSU_HU:      ok = !we;
      LSU_D:               ok = is64;
      LSU_WU:              ok = is64 && !we;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Size comes from funct3[1:0]; unsigned variants share it.
  function automatic logic aligned(
    input logic [2:0] f3,
    input logic [2:0] a
  );
    logic ok;
    ok = 1'b0;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = (a[0] == 1'b0);
      2'b10:   ok = (a[1:0] == 2'b00);
      default: ok = (a[2:0] == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables, store replication and
// load extraction with sign/zero extension.
module lsu_lane_align
  import pkg_lsu::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [2:0]      funct3_i,
  input  logic [OW-1:0]   offset_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [NB-1:0]   be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] sh;

  always_comb begin
    be_o    = '1;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = NB'(1) << offset_i;
        wdata_o = {NB{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = NB'(3) << offset_i;
        wdata_o = {(XLEN/16){wdata_i[15:0]}};
      end
      2'b10: begin
        be_o    = NB'(15) << offset_i;
        wdata_o = {(XLEN/32){wdata_i[31:0]}};
      end
      default: begin
        be_o    = '1;
        wdata_o = wdata_i;
      end
    endcase
  end

  always_comb begin
    sh = rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      LSU_B:   rdata_o = XLEN'($signed(sh[7:0]));
      LSU_BU:  rdata_o = XLEN'(sh[7:0]);
      LSU_H:   rdata_o = XLEN'($signed(sh[15:0]));
      LSU_HU:  rdata_o = XLEN'(sh[15:0]);
      LSU_W:   rdata_o = XLEN'($signed(sh[31:0]));
      LSU_WU:  rdata_o = XLEN'(sh[31:0]);
      default: rdata_o = sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core FSM and a
// variable-latency data memory, with decode errors and timeout.
module load_store_unit
  import pkg_lsu::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN/8-1:0]     mem_be,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic [XLEN-1:0]       mem_rdata
);

  localparam int   NB   = XLEN / 8;
  localparam int   OW   = $clog2(NB);
  localparam int   CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic IS64 = (XLEN == 64);

  state_t                state_q, state_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [XLEN-1:0]       rdata_q;
  logic [CW-1:0]         cnt_q;

  logic [NB-1:0]   be;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] rdata_ext;
  logic            req_ok;
  logic            accept;
  logic            timeout;
  logic            in_acc;

  assign req_ok = width_legal(req_we, req_funct3, IS64)
               && aligned(req_funct3, req_addr[2:0]);
  assign accept  = (state_q == IDLE) && req_valid;
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign in_acc  = (state_q == ACCESS);

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .funct3_i (f3_q),
    .offset_i (addr_q[OW-1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (mem_rdata),
    .be_o     (be),
    .wdata_o  (wdata_rep),
    .rdata_o  (rdata_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (req_valid) state_d = req_ok ? ACCESS : ERR;
      ACCESS: begin
        if (mem_ready)    state_d = RESP;
        else if (timeout) state_d = ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are forced to 0 outside ACCESS.
  always_comb begin
    req_ready  = (state_q == IDLE) && !reset;
    mem_valid  = in_acc;
    mem_we     = in_acc && we_q;
    mem_addr   = in_acc ? {addr_q[ADDR_WIDTH-1:OW], OW'(0)} : '0;
    mem_be     = !in_acc ? '0 : (we_q ? be : '1);
    mem_wdata  = in_acc ? wdata_rep : '0;
    resp_valid = (state_q == RESP) || (state_q == ERR);
    resp_err   = (state_q == ERR);
    resp_rdata = (state_q == RESP) ? rdata_q : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else if (in_acc) begin
      if (mem_ready) begin
        if (!we_q) rdata_q <= rdata_ext;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: 32-bit instance with a
// response scoreboard plus a 64-bit instance for doubleword paths.
module tb_load_store_unit;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        r_valid, r_ready, r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [63:0] r_wdata;
  logic        p_valid, p_err;
  logic [63:0] p_rdata;
  logic        m_valid, m_we;
  logic [31:0] m_addr;
  logic [7:0]  m_be;
  logic [63:0] m_wdata, m_rdata;

  assign mem_rdata = (mem_addr == 32'ha8) ? 32'hdeadbeef : 32'h0;
  assign m_rdata   = (m_addr == 32'ha8) ? 64'hfedcba98deadbeef : 64'h0;

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  load_store_unit #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(r_valid), .req_ready(r_ready), .req_we(r_we),
    .req_funct3(r_funct3), .req_addr(r_addr), .req_wdata(r_wdata),
    .resp_valid(p_valid), .resp_rdata(p_rdata), .resp_err(p_err),
    .mem_valid(m_valid), .mem_ready(1'b1), .mem_we(m_we),
    .mem_addr(m_addr), .mem_be(m_be), .mem_wdata(m_wdata),
    .mem_rdata(m_rdata)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every resp_valid pulse consumes one expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb.resp_err", 64'(resp_err), 64'(e.err));
        chk("sb.resp_rdata", 64'(resp_rdata), 64'(e.rdata));
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (req_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    sb.push_back({e_err, e_rd});
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  task automatic acc(input string tag, input logic we,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] e_be,
                     input logic [31:0] e_wd, input logic [31:0] e_rd);
    issue(we, f3, a, wd, 1'b0, e_rd);
    @(negedge clk);
    chk({tag, ".mem_valid"}, 64'(mem_valid), 64'd1);
    chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(a & 32'hffff_fffc));
    chk({tag, ".mem_be"}, 64'(mem_be), 64'(e_be));
    chk({tag, ".mem_we"}, 64'(mem_we), 64'(we));
    if (we) chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(e_wd));
    @(negedge clk);
    chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
  endtask

  task automatic bad(input string tag, input logic we,
                     input logic [2:0] f3, input logic [31:0] a);
    issue(we, f3, a, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, ".resp_err"}, 64'(resp_err), 64'd1);
    chk({tag, ".mem_valid"}, 64'(mem_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
  endtask

  task automatic acc64(input string tag, input logic [2:0] f3,
                       input logic [31:0] a, input logic [63:0] e_rd);
    @(posedge clk); #1;
    chk({tag, ".req_ready"}, 64'(r_ready), 64'd1);
    r_valid = 1'b1; r_funct3 = f3; r_addr = a;
    @(posedge clk); #1;
    r_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".mem_valid"}, 64'(m_valid), 64'd1);
    chk({tag, ".mem_addr"}, 64'(m_addr), 64'(a & 32'hffff_fff8));
    chk({tag, ".mem_be"}, 64'(m_be), 64'hff);
    @(negedge clk);
    chk({tag, ".resp_valid"}, 64'(p_valid), 64'd1);
    chk({tag, ".resp_err"}, 64'(p_err), 64'd0);
    chk({tag, ".resp_rdata"}, p_rdata, e_rd);
  endtask

  initial begin
    int nbad;
    reset = 1'b1; mem_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    r_valid = 1'b0; r_we = 1'b0; r_funct3 = 3'b0;
    r_addr = 32'h0; r_wdata = 64'h0;

    repeat (2) @(negedge clk);
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.mem_valid", 64'(mem_valid), 64'd0);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.outs", 64'({resp_err, resp_rdata, mem_we, mem_be}), 64'd0);
    chk("rst.mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle.req_ready", 64'(req_ready), 64'd1);

    acc("lw_a8", 1'b0, 3'b010, 32'ha8, 32'h0, 4'hf, 32'h0, 32'hdeadbeef);
    acc("lb_ab", 1'b0, 3'b000, 32'hab, 32'h0, 4'hf, 32'h0, 32'hffffffde);
    acc("lbu_ab", 1'b0, 3'b100, 32'hab, 32'h0, 4'hf, 32'h0, 32'h000000de);
    acc("lh_aa", 1'b0, 3'b001, 32'haa, 32'h0, 4'hf, 32'h0, 32'hffffdead);
    acc("lhu_a8", 1'b0, 3'b101, 32'ha8, 32'h0, 4'hf, 32'h0, 32'h0000beef);
    acc("sb_a9", 1'b1, 3'b000, 32'ha9, 32'h123456ab, 4'b0010,
        32'habababab, 32'h0);
    acc("sh_aa", 1'b1, 3'b001, 32'haa, 32'h0000beef, 4'b1100,
        32'hbeefbeef, 32'h0);

    bad("lw_misaligned", 1'b0, 3'b010, 32'ha6);
    bad("ld_on_rv32", 1'b0, 3'b011, 32'ha8);
    bad("shu_illegal", 1'b1, 3'b101, 32'ha8);

    mem_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h0);
    nbad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (mem_valid !== 1'b1 || resp_valid !== 1'b0) nbad++;
    end
    chk("tmo.wait_cycles", 64'(nbad), 64'd0);
    @(negedge clk);
    chk("tmo.resp_valid", 64'(resp_valid), 64'd1);
    chk("tmo.resp_err", 64'(resp_err), 64'd1);
    chk("tmo.mem_valid", 64'(mem_valid), 64'd0);

    issue(1'b1, 3'b010, 32'h44, 32'h11223344, 1'b0, 32'h0);
    nbad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({mem_valid, mem_we, mem_addr, mem_be, mem_wdata} !==
          {1'b1, 1'b1, 32'h44, 4'hf, 32'h11223344}) nbad++;
      if (i == 3) mem_ready = 1'b1;
    end
    chk("slow.stable", 64'(nbad), 64'd0);
    @(negedge clk);
    chk("slow.resp_valid", 64'(resp_valid), 64'd1);

    mem_ready = 1'b0;
    issue(1'b0, 3'b010, 32'ha8, 32'h0, 1'b0, 32'hdeadbeef);
    void'(sb.pop_back());
    @(negedge clk);
    chk("abort.mem_valid_pre", 64'(mem_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort.mem_valid", 64'(mem_valid), 64'd0);
    chk("abort.req_ready", 64'(req_ready), 64'd0);
    chk("abort.outs", 64'({resp_valid, resp_err, resp_rdata, mem_we, mem_be}),
        64'd0);
    chk("abort.mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    acc("lw_after_rst", 1'b0, 3'b010, 32'ha8, 32'h0, 4'hf, 32'h0,
        32'hdeadbeef);

    acc64("ld_a8", 3'b011, 32'ha8, 64'hfedcba98deadbeef);
    acc64("lwu_ac", 3'b110, 32'hac, 64'h00000000fedcba98);
    acc64("lw_ac", 3'b010, 32'hac, 64'hfffffffffedcba98);

    repeat (2) @(negedge clk);
    chk("sb.drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
